// File: rtl/multiplier_2x2.sv
// Registered unsigned 2x2 multiplier. Partial products are ANDed, reduced with two
// half adders, and captured in an output register with a one-cycle valid flag.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module multiplier_2x2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] multiplicand,
  input  logic [1:0] multiplier,
  input  logic       in_valid,
  output logic [3:0] product,
  output logic       out_valid
);
  logic pp0, pp1, pp2, pp3;
  logic p1, p2, p3;
  logic c1;
  logic [3:0] product_comb;

  assign pp0 = multiplicand[0] & multiplier[0];
  assign pp1 = multiplicand[1] & multiplier[0];
  assign pp2 = multiplicand[0] & multiplier[1];
  assign pp3 = multiplicand[1] & multiplier[1];

  half_adder u_ha1 (.a(pp1), .b(pp2), .s(p1), .c(c1));
  // The carry out of HA2 is the product MSB; no third adder is needed since 3*3=9 fits.
  half_adder u_ha2 (.a(pp3), .b(c1),  .s(p2), .c(p3));

  assign product_comb = {p3, p2, p1, pp0};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous and overrides in_valid.
    if (!rst_n) begin
      product   <= 4'd0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      product   <= product_comb;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multiplier_2x2.sv
// Self-checking bench for multiplier_2x2: directed reset/hold/pulse sequences,
// table-driven exhaustive sweep, and randomized traffic against an arithmetic model.

module tb_multiplier_2x2;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] multiplicand;
  logic [1:0] multiplier;
  logic       in_valid;
  logic [3:0] product;
  logic       out_valid;

  int n_checks = 0;
  int n_errors = 0;

  multiplier_2x2 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .in_valid     (in_valid),
    .product      (product),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] exp_product;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic step(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
    rst_n        = r;
    in_valid     = v;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    logic [3:0] m_product;
    logic       m_valid;
    int         pulses;

    for (int i = 0; i < 16; i++) begin
      vecs[i].a = 2'(i / 4);
      vecs[i].b = 2'(i % 4);
    end
    // Expected products written out independently of any arithmetic.
    vecs[0].exp_product  = 0; vecs[1].exp_product  = 0; vecs[2].exp_product  = 0; vecs[3].exp_product  = 0;
    vecs[4].exp_product  = 0; vecs[5].exp_product  = 1; vecs[6].exp_product  = 2; vecs[7].exp_product  = 3;
    vecs[8].exp_product  = 0; vecs[9].exp_product  = 2; vecs[10].exp_product = 4; vecs[11].exp_product = 6;
    vecs[12].exp_product = 0; vecs[13].exp_product = 3; vecs[14].exp_product = 6; vecs[15].exp_product = 9;

    // Reset held for two cycles with a valid 3x3 pair present.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 2'd3, 2'd3);
      check("reset_product", product, 0);
      check("reset_valid", out_valid, 0);
    end
    step(1'b1, 1'b1, 2'd3, 2'd3);
    check("post_reset_product", product, 9);
    check("post_reset_valid", out_valid, 1);

    // Exhaustive sweep, one pair per cycle, plus the internal HA1 carry probe.
    foreach (vecs[i]) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("sweep_product_%0dx%0d", vecs[i].a, vecs[i].b), product, vecs[i].exp_product);
      check("sweep_valid", out_valid, 1);
      check($sformatf("c1_probe_%0dx%0d", vecs[i].a, vecs[i].b), dut.c1,
            (vecs[i].exp_product == 9) ? 1 : 0);
    end

    // Hold: accept 2x3 then idle with 3x3 on the operands.
    step(1'b1, 1'b1, 2'd2, 2'd3);
    check("hold_accept_product", product, 6);
    check("hold_accept_valid", out_valid, 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 2'd3, 2'd3);
      check("hold_product", product, 6);
      check("hold_valid", out_valid, 0);
    end

    // Single-cycle pulses: 1x1, two idle cycles, 3x2.
    pulses = 0;
    step(1'b1, 1'b1, 2'd1, 2'd1);
    check("pulse1_product", product, 1);
    pulses += int'(out_valid);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 2'd0, 2'd0);
      check("pulse_gap_product", product, 1);
      pulses += int'(out_valid);
    end
    step(1'b1, 1'b1, 2'd3, 2'd2);
    check("pulse2_product", product, 6);
    pulses += int'(out_valid);
    step(1'b1, 1'b0, 2'd1, 2'd1);
    pulses += int'(out_valid);
    check("pulse_count", pulses, 2);

    // Reset mid-stream of 3x3.
    step(1'b1, 1'b1, 2'd3, 2'd3);
    check("stream_product", product, 9);
    step(1'b0, 1'b1, 2'd3, 2'd3);
    check("midreset_product", product, 0);
    check("midreset_valid", out_valid, 0);
    step(1'b1, 1'b1, 2'd3, 2'd3);
    check("midreset_release_product", product, 9);
    check("midreset_release_valid", out_valid, 1);

    // Randomized traffic against an arithmetic reference model.
    m_product = 4'd9;
    m_valid   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic       r, v;
      logic [1:0] a, b;
      r = ($urandom_range(0, 19) != 0);
      v = $urandom_range(0, 2) != 0;
      a = 2'($urandom);
      b = 2'($urandom);
      step(r, v, a, b);
      if (!r) begin
        m_product = 4'd0;
        m_valid   = 1'b0;
      end else if (v) begin
        m_product = 4'(int'(a) * int'(b));
        m_valid   = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      check("rand_product", product, m_product);
      check("rand_valid", out_valid, m_valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multiplier_2x2.md
# multiplier_2x2

Registered unsigned 2-bit by 2-bit multiplier producing a 4-bit product. It is the smallest arithmetic leaf in the multiplier family and feeds wider array multipliers or sits directly behind operand registers. The product is formed combinationally from a partial-product AND array and half-adder reduction, then captured in an output register with a valid flag.

## Interface

- No parameters; all widths fixed.
- Clk  input  1  single system clock; all state updates on rising edge.
- Rst_n  input  1  synchronous, active-low reset; sampled on rising edge of Clk.
- product  output  4  registered unsigned product, multiplicand × multiplier.
- multiplicand  input  2  unsigned operand A, 0..3.
- multiplier  input  2  unsigned operand B, 0..3.
- in_valid  input  1  operands valid this cycle; product register loads only when high.
- out_valid  output  1  high for one cycle per accepted operand pair; product valid while high and held afterwards.

## Operation

- Operands unsigned; no sign extension; result range 0..9; no overflow possible in 4 bits.
- Partial products: pp0 = a0&b0, pp1 = a1&b0, pp2 = a0&b1, pp3 = a1&b1.
- Reduction, half adders only:
  - p0 = pp0
  - HA1: p1 = pp1^pp2, c1 = pp1&pp2
  - HA2: p2 = pp3^c1, p3 = pp3&c1
- Implement the array structurally, with a half-adder submodule instantiated twice. Behavioural `*` is not used.
- Register stage:
  - On a rising edge with Rst_n=1 and in_valid=1: product <= combinational result; out_valid <= 1.
  - On a rising edge with Rst_n=1 and in_valid=0: product holds its previous value; out_valid <= 0.
- No back-pressure; a new pair is accepted every cycle in_valid is high.
- Operand changes while in_valid=0 have no effect on outputs.

## Timing

- Reset: on a rising edge with Rst_n=0, product <= 4'd0 and out_valid <= 0. Reset dominates in_valid.
- Reset mid-stream: the pair presented in the reset cycle is discarded. The first valid output follows the first accepted pair after Rst_n returns high.
- Latency: exactly 1 cycle. Operands sampled at edge N appear on product with out_valid=1 after edge N, until edge N+1.
- Throughput: 1 product per cycle; back-to-back in_valid yields back-to-back out_valid.
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- Combinational array depth is 1 AND plus 2 half adders and must close timing at the system clock.
- Before the first accepted pair after reset, product reads 0.

## Test plan

- Reset: hold Rst_n=0 for 2 cycles with operands 3,3 and in_valid=1 -> product=0, out_valid=0 throughout. Release reset -> next edge gives product=9, out_valid=1.
- Exhaustive sweep: multiplicand 0..3 × multiplier 0..3, one pair per cycle, in_valid=1 (16 consecutive cycles) -> each product equals A×B one cycle later. Products in order: 0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9. out_valid stays high continuously.
- Hold: accept 2×3 (product=6), then drop in_valid and drive 3×3 -> product stays 6, out_valid=0 from the next edge.
- Single-cycle valid pulses: 1×1 pulse, two idle cycles, then 3×2 pulse -> out_valid pulses exactly twice, one cycle each. Products are 1, then 6.
- Reset mid-stream: stream 3×3 continuously and assert Rst_n=0 for one cycle -> product=0, out_valid=0 after that edge. Product=9, out_valid=1 on the edge after release.
- Structural check: no multiply operator in RTL. The half-adder carry c1 is 1 only for A∈{3} with B∈{3}, giving product 9; confirm via internal probe.
